fir_stim_gen: RTL and testbench

FIR_STIM_GEN -- requirements
Module: fir_stim_gen

---
 rtl/fir_stim_gen.sv | 140 ++++++++++++++
 tb/tb_fir_stim_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fir_stim_gen.sv
// Burst stimulus generator for an FIR under test: PRBS-7, impulse, step or alternating symbols.
// Optional trailing zero-flush of N_TAPS symbols is compiled in when FIR_STIM_FLUSH_EN is defined.
module fir_stim_gen #(
    parameter int BW_in     = 2,
    parameter int BURST_LEN = 32,
    parameter int N_TAPS    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [BW_in-1:0] x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = (BURST_LEN > N_TAPS) ? BURST_LEN : N_TAPS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]    LAST_SYM = CW'(BURST_LEN - 1);
`ifdef FIR_STIM_FLUSH_EN
    localparam logic [CW-1:0]    LAST_FLUSH = CW'(N_TAPS - 1);
`endif
    localparam logic [BW_in-1:0] POS_MAX  = {1'b0, {(BW_in-1){1'b1}}};
    localparam logic [BW_in-1:0] NEG_MAX  = ~POS_MAX + 1'b1;
    localparam logic [6:0]       LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef FIR_STIM_FLUSH_EN
        FLUSH = 2'd2,
`endif
        RUN   = 2'd1
    } state_t;

    typedef enum logic [1:0] {
        MODE_PRBS    = 2'd0,
        MODE_IMPULSE = 2'd1,
        MODE_STEP    = 2'd2,
        MODE_ALT     = 2'd3
    } mode_t;

    state_t        state, state_d;
    mode_t         mode_q, mode_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [6:0]    lfsr, lfsr_d;
    logic          done_q, done_d;
    logic [BW_in-1:0] pattern;

    // Zero-extension lets BW_in exceed the 7-bit LFSR without an out-of-range slice.
    logic [BW_in+6:0] lfsr_ext;
    assign lfsr_ext = {{BW_in{1'b0}}, lfsr};

    always_comb begin
        pattern = '0;
        unique case (mode_q)
            MODE_PRBS:    pattern = lfsr_ext[BW_in-1:0];
            MODE_IMPULSE: pattern = (cnt == '0) ? POS_MAX : '0;
            MODE_STEP:    pattern = POS_MAX;
            MODE_ALT:     pattern = cnt[0] ? NEG_MAX : POS_MAX;
            default:      pattern = '0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        cnt_d   = cnt;
        lfsr_d  = lfsr;
        done_d  = 1'b0;
        x_out   = '0;
        x_valid = 1'b0;
        busy    = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (start) begin
                    mode_d  = mode_t'(mode);
                    cnt_d   = '0;
                    lfsr_d  = LFSR_SEED;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_out   = pattern;
                x_valid = 1'b1;
                if (mode_q == MODE_PRBS) begin
                    lfsr_d = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                end
                if (cnt == LAST_SYM) begin
                    cnt_d = '0;
`ifdef FIR_STIM_FLUSH_EN
                    state_d = FLUSH;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`ifdef FIR_STIM_FLUSH_EN
            FLUSH: begin
                x_valid = 1'b1;
                if (cnt == LAST_FLUSH) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // done is registered so it lands in the first IDLE cycle after the last symbol.
    assign done = done_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= MODE_PRBS;
            cnt    <= '0;
            lfsr   <= LFSR_SEED;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            mode_q <= mode_d;
            cnt    <= cnt_d;
            lfsr   <= lfsr_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed, table-driven bench for fir_stim_gen; expected flush length follows FIR_STIM_FLUSH_EN.
module tb_fir_stim_gen;

    localparam int BW = 2;
    localparam int BL = 4;
    localparam int NT = 2;
`ifdef FIR_STIM_FLUSH_EN
    localparam int FL = NT;
`else
    localparam int FL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, start_b;
    logic [1:0]    mode, mode_b;
    logic [BW-1:0] x_out, x_out_b;
    logic          x_valid, busy, done;
    logic          x_valid_b, busy_b, done_b;

    always #5 clk = ~clk;

    fir_stim_gen #(.BW_in(BW), .BURST_LEN(BL), .N_TAPS(NT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
    );

    fir_stim_gen #(.BW_in(BW), .BURST_LEN(3), .N_TAPS(NT)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
        .x_out(x_out_b), .x_valid(x_valid_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        string                  name;
        logic [1:0]             mode;
        logic [BL-1:0][BW-1:0]  sym;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " x_valid"}, 32'(x_valid), 0);
        check({tag, " x_out"},   32'(x_out),   0);
        check({tag, " busy"},    32'(busy),    0);
        check({tag, " done"},    32'(done),    0);
    endtask

    // One full burst on dut; mode is flipped right after launch and must not matter.
    task automatic run_burst(input vec_t v);
        start = 1'b1;
        mode  = v.mode;
        tick();
        start = 1'b0;
        mode  = v.mode ^ 2'b01;
        for (int i = 0; i < BL; i++) begin
            check($sformatf("%s sym%0d x_out", v.name, i), 32'(x_out), 32'(v.sym[i]));
            check($sformatf("%s sym%0d x_valid", v.name, i), 32'(x_valid), 1);
            check($sformatf("%s sym%0d busy", v.name, i), 32'(busy), 1);
            tick();
        end
        for (int i = 0; i < FL; i++) begin
            check($sformatf("%s flush%0d x_out", v.name, i), 32'(x_out), 0);
            check($sformatf("%s flush%0d x_valid", v.name, i), 32'(x_valid), 1);
            tick();
        end
        check({v.name, " done"},       32'(done),    1);
        check({v.name, " done busy"},  32'(busy),    0);
        check({v.name, " done valid"}, 32'(x_valid), 0);
        tick();
        check({v.name, " done pulse"}, 32'(done),    0);
    endtask

    initial begin
        vecs[0] = '{name: "impulse", mode: 2'd1, sym: {2'b00, 2'b00, 2'b00, 2'b01}};
        vecs[1] = '{name: "step",    mode: 2'd2, sym: {2'b01, 2'b01, 2'b01, 2'b01}};
        vecs[2] = '{name: "alt",     mode: 2'd3, sym: {2'b11, 2'b01, 2'b11, 2'b01}};
        vecs[3] = '{name: "prbs",    mode: 2'd0, sym: {2'b00, 2'b00, 2'b10, 2'b11}};

        rst = 1'b1; start = 1'b1; mode = 2'd2; start_b = 1'b0; mode_b = 2'd0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0; start = 1'b0;
        tick();
        check_idle("post-reset");

        for (int k = 0; k < 4; k++) begin
            run_burst(vecs[k]);
        end

        // PRBS on a 3-symbol burst: 11,10,00, leaving the fourth LFSR state 7'h78.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("prbs3 sym0", 32'(x_out_b), 32'h3);
        tick();
        check("prbs3 sym1", 32'(x_out_b), 32'h2);
        tick();
        check("prbs3 sym2", 32'(x_out_b), 32'h0);
        check("prbs3 valid", 32'(x_valid_b), 1);
        for (int i = 0; i <= FL; i++) tick();
        check("prbs3 done", 32'(done_b), 1);
        check("prbs3 lfsr", 32'(dut_b.lfsr), 32'h78);

        // start held high: bursts separated by exactly one IDLE cycle carrying done.
        start = 1'b1;
        mode  = 2'd2;
        tick();
        for (int c = 0; c < 20; c++) begin
            int ph;
            ph = c % (BL + FL + 1);
            if (ph < BL + FL) begin
                check($sformatf("b2b c%0d x_valid", c), 32'(x_valid), 1);
                check($sformatf("b2b c%0d x_out", c), 32'(x_out), (ph < BL) ? 1 : 0);
                check($sformatf("b2b c%0d done", c), 32'(done), 0);
            end else begin
                check($sformatf("b2b c%0d done", c), 32'(done), 1);
                check($sformatf("b2b c%0d busy", c), 32'(busy), 0);
            end
            tick();
        end
        start = 1'b0;
        begin
            int waited;
            waited = 0;
            while ((busy || done) && waited < 20) begin
                tick();
                waited++;
            end
            check("b2b drain timeout", 32'(waited < 20), 1);
        end
        tick();
        check_idle("b2b stopped");

        // Reset on the second RUN cycle: no done, and the next burst replays from the seed.
        start = 1'b1;
        mode  = 2'd0;
        tick();
        start = 1'b0;
        tick();
        check("rst-mid valid before", 32'(x_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst-mid valid", 32'(x_valid), 0);
        check("rst-mid busy",  32'(busy),    0);
        for (int i = 0; i < BL + FL + 2; i++) begin
            check($sformatf("rst-mid no done %0d", i), 32'(done), 0);
            tick();
        end
        run_burst(vecs[3]);

        // start pulsed mid-burst must neither stretch it nor queue another.
        start = 1'b1;
        mode  = 2'd2;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 2; i < BL + FL; i++) tick();
        check("busy-start done",      32'(done), 1);
        check("busy-start done busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("busy-start idle %0d busy", i), 32'(busy), 0);
            check($sformatf("busy-start idle %0d valid", i), 32'(x_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not end, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
